branch_rs: RTL and testbench
============================

Name: branch_rs

Overview:
- Reservation station directly upstream of the combinational branch unit; one issue per cycle.
- Buffers dispatched branch/jump µops (BEQ..BGEU, JAL, JALR) until both source operands are available.
- Captures operands from the CDB, then issues the oldest ready entry with fully resolved op1/op2/pc/imm/alu_op/rob_tag/prd.
- Organised as a compacting shift queue: entry 0 is always oldest.

Parameters:
DATA_WIDTH, 32, operand/PC width
ROB_WIDTH, 4, ROB tag width
PREG_WIDTH, 7, physical register index width
DEPTH, 4, number of RS entries (>=2)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_flush  in  1  mispredict flush; clears all entries
i_disp_valid  in  1  dispatch request
o_disp_ready  out  1  entry available (count < DEPTH)
i_disp_alu_op  in  4  {0,funct3} branch; 4'b1000 JAL; 4'b1001 JALR
i_disp_pc, i_disp_imm  in  DATA_WIDTH  instruction PC / sign-extended immediate
i_disp_rob_tag  in  ROB_WIDTH  ROB tag
i_disp_prd  in  PREG_WIDTH  destination preg (link register)
i_disp_prs1, i_disp_prs2  in  PREG_WIDTH  source pregs
i_disp_rs1_rdy, i_disp_rs2_rdy  in  1  operand already available
i_disp_rs1_val, i_disp_rs2_val  in  DATA_WIDTH  operand value when ready
i_cdb_valid  in  1  CDB broadcast valid
i_cdb_preg  in  PREG_WIDTH  broadcast preg
i_cdb_data  in  DATA_WIDTH  broadcast value
o_issue_valid  out  1  issuing this cycle (drives branch unit i_valid)
o_issue_op1, o_issue_op2, o_issue_pc, o_issue_imm  out  DATA_WIDTH  to branch unit
o_issue_alu_op  out  4  to branch unit
o_issue_rob_tag  out  ROB_WIDTH  to branch unit
o_issue_prd  out  PREG_WIDTH  to branch unit
o_count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, i_rst_n=0): all valid bits and count cleared; o_issue_valid=0, o_count=0, o_disp_ready=1. Payload registers need not reset. Issue data outputs are 0 whenever o_issue_valid=0.
- Entry state: valid, rdy1, rdy2, val1, val2, prs1, prs2, alu_op, pc, imm, rob_tag, prd.
- Dispatch is accepted when i_disp_valid && o_disp_ready && !i_flush. The entry is written at the next free slot after compaction. o_disp_ready = (count < DEPTH); there is no same-cycle credit from an issue.
- Dispatch-cycle CDB capture: if i_cdb_valid and i_cdb_preg matches a not-ready source, that operand is written ready with i_cdb_data. This prevents a lost wakeup.
- Wakeup: each cycle, every valid entry with a not-ready source matching i_cdb_preg (i_cdb_valid=1) sets that rdy bit and latches the data at the clock edge. Both sources may wake on the same broadcast.
- Issue select (combinational): the lowest-index valid entry with rdy1&&rdy2, using registered ready bits only.
  - o_issue_valid=1 and fields are driven from that entry.
  - The entry is removed at the edge; younger entries shift down by one.
  - The branch unit always accepts, so there is no stall input.
- Latency: a µop dispatched ready at edge N issues in cycle N+1. A CDB wakeup at cycle N allows issue in cycle N+1.
- JAL: sources are ignored; the dispatcher sets rdy1=rdy2=1. JALR: rdy2 is set by the dispatcher.
- Simultaneous issue + dispatch: compaction and append happen in the same edge; count is unchanged.
- i_flush has priority over everything. All valids and count clear at the edge. A same-cycle dispatch is dropped. o_issue_valid is still driven combinationally that cycle; the consumer must qualify it with flush.
- No entry may be written with count==DEPTH. An assertion fires if i_disp_valid && !o_disp_ready is ever accepted.

Optional Feature:
- Macro: BRANCH_RS_BYPASS_EN.
- Defined: an entry whose only missing source(s) match the current CDB broadcast is issue-eligible in the same cycle. The operand is muxed from i_cdb_data, giving 0-cycle wakeup-to-issue.
- Undefined: issue eligibility uses registered ready bits only, giving 1-cycle wakeup-to-issue.

Decomposition:
- Package branch_pkg holds:
  - alu_op constants: OP_BEQ=4'b0000, OP_BNE=4'b0001, OP_BLT=4'b0100, OP_BGE=4'b0101, OP_BLTU=4'b0110, OP_BGEU=4'b0111, OP_JAL=4'b1000, OP_JALR=4'b1001.
  - The packed rs_entry_t struct.
- One sub-module, branch_rs_wakeup: per-source CDB compare and ready/value update. It is instantiated 2×DEPTH plus 2 for the dispatch path.

Test Plan:
- Reset then dispatch BEQ, both ready, rs1=5, rs2=5, pc=0x100, imm=0x20 -> next cycle o_issue_valid=1, op1=op2=5, alu_op=0, count returns to 0.
- Dispatch BNE with rs2 waiting on preg 12; CDB preg 12 data 0x7 two cycles later -> issue exactly one cycle after the CDB with op2=0x7 (same cycle when BRANCH_RS_BYPASS_EN is defined).
- Fill 4 not-ready entries -> o_disp_ready=0, count=4; further i_disp_valid is ignored. Wake entry 2 -> it issues, count=3, entry order preserved.
- Entries 0 and 1 become ready on the same broadcast -> entry 0 (older rob_tag) issues first, entry 1 issues next cycle.
- i_flush with 3 entries plus a simultaneous dispatch -> count=0 after the edge and the dispatched µop never issues.
- Dispatch with i_cdb_valid on prs1=9 in the same cycle -> entry captured ready with the CDB value and issues next cycle; async reset asserted mid-stream -> outputs are 0 immediately.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: branch/jump alu_op encodings and the default-width reservation station entry record.
package branch_pkg;
  localparam logic [3:0] OP_BEQ  = 4'b0000;
  localparam logic [3:0] OP_BNE  = 4'b0001;
  localparam logic [3:0] OP_BLT  = 4'b0100;
  localparam logic [3:0] OP_BGE  = 4'b0101;
  localparam logic [3:0] OP_BLTU = 4'b0110;
  localparam logic [3:0] OP_BGEU = 4'b0111;
  localparam logic [3:0] OP_JAL  = 4'b1000;
  localparam logic [3:0] OP_JALR = 4'b1001;
  typedef struct packed {
    logic        valid;
    logic        rdy1;
    logic        rdy2;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [6:0]  prs1;
    logic [6:0]  prs2;
    logic [3:0]  alu_op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  rob_tag;
    logic [6:0]  prd;
  } rs_entry_t;
endpackage

// File: rtl/branch_rs_wakeup.sv
// branch_rs_wakeup: one source operand's CDB compare; marks it ready and takes the broadcast value on a match.
module branch_rs_wakeup
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PREG_WIDTH = 7
) (
  input  logic                  cdb_valid,
  input  logic [PREG_WIDTH-1:0] cdb_preg,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  input  logic                  rdy,
  input  logic [PREG_WIDTH-1:0] prs,
  input  logic [DATA_WIDTH-1:0] val,
  output logic                  rdy_n,
  output logic [DATA_WIDTH-1:0] val_n
);
  logic hit;
  assign hit   = cdb_valid && !rdy && prs == cdb_preg;
  assign rdy_n = rdy || hit;
  assign val_n = hit ? cdb_data : val;
endmodule

// File: rtl/branch_rs.sv
// branch_rs: compacting-shift reservation station feeding the branch unit, oldest-ready issue.
// BRANCH_RS_BYPASS_EN lets an entry woken by the current CDB broadcast issue in the same cycle.
module branch_rs
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int PREG_WIDTH = 7,
  parameter int DEPTH      = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_disp_valid,
  output logic                         o_disp_ready,
  input  logic [3:0]                   i_disp_alu_op,
  input  logic [DATA_WIDTH-1:0]        i_disp_pc,
  input  logic [DATA_WIDTH-1:0]        i_disp_imm,
  input  logic [ROB_WIDTH-1:0]         i_disp_rob_tag,
  input  logic [PREG_WIDTH-1:0]        i_disp_prd,
  input  logic [PREG_WIDTH-1:0]        i_disp_prs1,
  input  logic [PREG_WIDTH-1:0]        i_disp_prs2,
  input  logic                         i_disp_rs1_rdy,
  input  logic                         i_disp_rs2_rdy,
  input  logic [DATA_WIDTH-1:0]        i_disp_rs1_val,
  input  logic [DATA_WIDTH-1:0]        i_disp_rs2_val,
  input  logic                         i_cdb_valid,
  input  logic [PREG_WIDTH-1:0]        i_cdb_preg,
  input  logic [DATA_WIDTH-1:0]        i_cdb_data,
  output logic                         o_issue_valid,
  output logic [DATA_WIDTH-1:0]        o_issue_op1,
  output logic [DATA_WIDTH-1:0]        o_issue_op2,
  output logic [DATA_WIDTH-1:0]        o_issue_pc,
  output logic [DATA_WIDTH-1:0]        o_issue_imm,
  output logic [3:0]                   o_issue_alu_op,
  output logic [ROB_WIDTH-1:0]         o_issue_rob_tag,
  output logic [PREG_WIDTH-1:0]        o_issue_prd,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  logic [DEPTH-1:0] valid, rdy1, rdy2, w_rdy1, w_rdy2, e_rdy1, e_rdy2, elig, n_valid, n_rdy1, n_rdy2;
  logic [DATA_WIDTH-1:0] val1[DEPTH], val2[DEPTH], w_val1[DEPTH], w_val2[DEPTH], e_val1[DEPTH], e_val2[DEPTH];
  logic [DATA_WIDTH-1:0] pc[DEPTH], imm[DEPTH], n_val1[DEPTH], n_val2[DEPTH], n_pc[DEPTH], n_imm[DEPTH];
  logic [PREG_WIDTH-1:0] prs1[DEPTH], prs2[DEPTH], prd[DEPTH], n_prs1[DEPTH], n_prs2[DEPTH], n_prd[DEPTH];
  logic [3:0] alu_op[DEPTH], n_alu_op[DEPTH];
  logic [ROB_WIDTH-1:0] rob_tag[DEPTH], n_rob_tag[DEPTH];
  logic [CW-1:0] count, slot;
  logic [IW-1:0] sel, src;
  logic d_rdy1, d_rdy2, disp_fire, shift;
  logic [DATA_WIDTH-1:0] d_val1, d_val2;
  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    branch_rs_wakeup #(.DATA_WIDTH(DATA_WIDTH), .PREG_WIDTH(PREG_WIDTH)) u_w1 (
      .cdb_valid(i_cdb_valid), .cdb_preg(i_cdb_preg), .cdb_data(i_cdb_data),
      .rdy(rdy1[g]), .prs(prs1[g]), .val(val1[g]), .rdy_n(w_rdy1[g]), .val_n(w_val1[g]));
    branch_rs_wakeup #(.DATA_WIDTH(DATA_WIDTH), .PREG_WIDTH(PREG_WIDTH)) u_w2 (
      .cdb_valid(i_cdb_valid), .cdb_preg(i_cdb_preg), .cdb_data(i_cdb_data),
      .rdy(rdy2[g]), .prs(prs2[g]), .val(val2[g]), .rdy_n(w_rdy2[g]), .val_n(w_val2[g]));
  end
  // Dispatch-cycle capture so a broadcast coinciding with dispatch is not lost
  branch_rs_wakeup #(.DATA_WIDTH(DATA_WIDTH), .PREG_WIDTH(PREG_WIDTH)) u_d1 (
    .cdb_valid(i_cdb_valid), .cdb_preg(i_cdb_preg), .cdb_data(i_cdb_data),
    .rdy(i_disp_rs1_rdy), .prs(i_disp_prs1), .val(i_disp_rs1_val), .rdy_n(d_rdy1), .val_n(d_val1));
  branch_rs_wakeup #(.DATA_WIDTH(DATA_WIDTH), .PREG_WIDTH(PREG_WIDTH)) u_d2 (
    .cdb_valid(i_cdb_valid), .cdb_preg(i_cdb_preg), .cdb_data(i_cdb_data),
    .rdy(i_disp_rs2_rdy), .prs(i_disp_prs2), .val(i_disp_rs2_val), .rdy_n(d_rdy2), .val_n(d_val2));
`ifdef BRANCH_RS_BYPASS_EN
  assign e_rdy1 = w_rdy1;
  assign e_rdy2 = w_rdy2;
  assign e_val1 = w_val1;
  assign e_val2 = w_val2;
`else
  assign e_rdy1 = rdy1;
  assign e_rdy2 = rdy2;
  assign e_val1 = val1;
  assign e_val2 = val2;
`endif
  assign elig = valid & e_rdy1 & e_rdy2;
  always_comb begin
    sel = '0;
    for (int i = DEPTH-1; i >= 0; i--) if (elig[i]) sel = IW'(i);
  end
  assign o_issue_valid   = |elig;
  assign o_issue_op1     = o_issue_valid ? e_val1[sel]  : '0;
  assign o_issue_op2     = o_issue_valid ? e_val2[sel]  : '0;
  assign o_issue_pc      = o_issue_valid ? pc[sel]      : '0;
  assign o_issue_imm     = o_issue_valid ? imm[sel]     : '0;
  assign o_issue_alu_op  = o_issue_valid ? alu_op[sel]  : '0;
  assign o_issue_rob_tag = o_issue_valid ? rob_tag[sel] : '0;
  assign o_issue_prd     = o_issue_valid ? prd[sel]     : '0;
  assign o_disp_ready    = count < CW'(DEPTH);
  assign o_count         = count;
  assign disp_fire       = i_disp_valid && o_disp_ready && !i_flush;
  // Entries at or above the issuing slot move down by one; the new uop lands just past the survivors
  always_comb begin
    slot = count - CW'(o_issue_valid);
    n_valid = '0;
    n_rdy1 = '0;
    n_rdy2 = '0;
    n_val1 = val1;
    n_val2 = val2;
    n_prs1 = prs1;
    n_prs2 = prs2;
    n_alu_op = alu_op;
    n_pc = pc;
    n_imm = imm;
    n_rob_tag = rob_tag;
    n_prd = prd;
    shift = 1'b0;
    src = '0;
    for (int i = 0; i < DEPTH; i++) begin
      shift = o_issue_valid && IW'(i) >= sel;
      src = shift ? IW'(i+1) : IW'(i);
      n_valid[i] = valid[src] && !(shift && i == DEPTH-1);
      n_rdy1[i] = w_rdy1[src];
      n_rdy2[i] = w_rdy2[src];
      n_val1[i] = w_val1[src];
      n_val2[i] = w_val2[src];
      n_prs1[i] = prs1[src];
      n_prs2[i] = prs2[src];
      n_alu_op[i] = alu_op[src];
      n_pc[i] = pc[src];
      n_imm[i] = imm[src];
      n_rob_tag[i] = rob_tag[src];
      n_prd[i] = prd[src];
      if (disp_fire && slot == CW'(i)) begin
        n_valid[i] = 1'b1;
        n_rdy1[i] = d_rdy1;
        n_rdy2[i] = d_rdy2;
        n_val1[i] = d_val1;
        n_val2[i] = d_val2;
        n_prs1[i] = i_disp_prs1;
        n_prs2[i] = i_disp_prs2;
        n_alu_op[i] = i_disp_alu_op;
        n_pc[i] = i_disp_pc;
        n_imm[i] = i_disp_imm;
        n_rob_tag[i] = i_disp_rob_tag;
        n_prd[i] = i_disp_prd;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid <= '0;
      count <= '0;
    end else if (i_flush) begin
      valid <= '0;
      count <= '0;
    end else begin
      valid <= n_valid;
      count <= slot + CW'(disp_fire);
    end
  end
  always_ff @(posedge i_clk) begin
    rdy1 <= n_rdy1;
    rdy2 <= n_rdy2;
    val1 <= n_val1;
    val2 <= n_val2;
    prs1 <= n_prs1;
    prs2 <= n_prs2;
    alu_op <= n_alu_op;
    pc <= n_pc;
    imm <= n_imm;
    rob_tag <= n_rob_tag;
    prd <= n_prd;
  end
  a_no_overfill: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(disp_fire && count == CW'(DEPTH)));
endmodule

// File: tb/tb_branch_rs.sv
// tb_branch_rs: directed scenario tests for branch_rs; inputs change on the falling edge, outputs checked 1ns later.
module tb_branch_rs;
  logic        i_clk, i_rst_n, i_flush, i_disp_valid, o_disp_ready;
  logic [3:0]  i_disp_alu_op;
  logic [31:0] i_disp_pc, i_disp_imm, i_disp_rs1_val, i_disp_rs2_val, i_cdb_data;
  logic [3:0]  i_disp_rob_tag;
  logic [6:0]  i_disp_prd, i_disp_prs1, i_disp_prs2, i_cdb_preg;
  logic        i_disp_rs1_rdy, i_disp_rs2_rdy, i_cdb_valid, o_issue_valid;
  logic [31:0] o_issue_op1, o_issue_op2, o_issue_pc, o_issue_imm;
  logic [3:0]  o_issue_alu_op, o_issue_rob_tag;
  logic [6:0]  o_issue_prd;
  logic [2:0]  o_count;
  int checks = 0, failures = 0, cyc = 0;
  logic [3:0]  h_rob[$];
  logic [31:0] h_op1[$], h_op2[$];
  int          h_cyc[$];

  branch_rs dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_disp_valid(i_disp_valid),
    .o_disp_ready(o_disp_ready), .i_disp_alu_op(i_disp_alu_op), .i_disp_pc(i_disp_pc),
    .i_disp_imm(i_disp_imm), .i_disp_rob_tag(i_disp_rob_tag), .i_disp_prd(i_disp_prd),
    .i_disp_prs1(i_disp_prs1), .i_disp_prs2(i_disp_prs2), .i_disp_rs1_rdy(i_disp_rs1_rdy),
    .i_disp_rs2_rdy(i_disp_rs2_rdy), .i_disp_rs1_val(i_disp_rs1_val), .i_disp_rs2_val(i_disp_rs2_val),
    .i_cdb_valid(i_cdb_valid), .i_cdb_preg(i_cdb_preg), .i_cdb_data(i_cdb_data),
    .o_issue_valid(o_issue_valid), .o_issue_op1(o_issue_op1), .o_issue_op2(o_issue_op2),
    .o_issue_pc(o_issue_pc), .o_issue_imm(o_issue_imm), .o_issue_alu_op(o_issue_alu_op),
    .o_issue_rob_tag(o_issue_rob_tag), .o_issue_prd(o_issue_prd), .o_count(o_count));

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Issue history seen by the branch unit (flush-qualified, as a real consumer would)
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (i_rst_n && o_issue_valid && !i_flush) begin
      h_rob.push_back(o_issue_rob_tag);
      h_op1.push_back(o_issue_op1);
      h_op2.push_back(o_issue_op2);
      h_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic idle();
    i_disp_valid = 1'b0;
    i_cdb_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [3:0] rob, input logic [6:0] p1, input logic r1,
                      input logic [31:0] v1, input logic [6:0] p2, input logic r2, input logic [31:0] v2);
    i_disp_valid = 1'b1;
    i_disp_alu_op = op;
    i_disp_rob_tag = rob;
    i_disp_prd = {3'b0, rob};
    i_disp_pc = 32'h1000 + {28'b0, rob};
    i_disp_imm = 32'h8;
    i_disp_prs1 = p1;
    i_disp_rs1_rdy = r1;
    i_disp_rs1_val = v1;
    i_disp_prs2 = p2;
    i_disp_rs2_rdy = r2;
    i_disp_rs2_val = v2;
  endtask

  task automatic cdb(input logic [6:0] p, input logic [31:0] d);
    i_cdb_valid = 1'b1;
    i_cdb_preg = p;
    i_cdb_data = d;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    idle();
    disp(0, 0, 0, 0, 0, 0, 0, 0);
    i_disp_valid = 1'b0;
    cdb(0, 0);
    i_cdb_valid = 1'b0;
    repeat (2) tick();
    #1;
    checks++; if (o_issue_valid !== 1'b0) begin failures++; $display("FAIL reset_issue_valid got=%b exp=0", o_issue_valid); end
    checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    checks++; if (o_disp_ready !== 1'b1) begin failures++; $display("FAIL reset_disp_ready got=%b exp=1", o_disp_ready); end
    checks++; if (o_issue_op1 !== 32'd0) begin failures++; $display("FAIL reset_op1 got=%h exp=0", o_issue_op1); end
    i_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    tick();
    disp(4'b0000, 4'd1, 7'd0, 1'b1, 32'd5, 7'd0, 1'b1, 32'd5);
    i_disp_pc = 32'h100;
    i_disp_imm = 32'h20;
    #1;
    checks++; if (o_issue_valid !== 1'b0) begin failures++; $display("FAIL basic_empty_issue got=%b exp=0", o_issue_valid); end
    tick();
    idle();
    #1;
    checks++; if (o_issue_valid !== 1'b1) begin failures++; $display("FAIL basic_issue_valid got=%b exp=1", o_issue_valid); end
    checks++; if (o_issue_op1 !== 32'd5 || o_issue_op2 !== 32'd5) begin failures++; $display("FAIL basic_ops got=%h/%h exp=5/5", o_issue_op1, o_issue_op2); end
    checks++; if (o_issue_pc !== 32'h100 || o_issue_imm !== 32'h20) begin failures++; $display("FAIL basic_pc_imm got=%h/%h exp=100/20", o_issue_pc, o_issue_imm); end
    checks++; if (o_issue_alu_op !== 4'd0 || o_issue_rob_tag !== 4'd1 || o_issue_prd !== 7'd1) begin failures++; $display("FAIL basic_fields got=%h/%h/%h exp=0/1/1", o_issue_alu_op, o_issue_rob_tag, o_issue_prd); end
    checks++; if (o_count !== 3'd1) begin failures++; $display("FAIL basic_count1 got=%0d exp=1", o_count); end
    tick();
    #1;
    checks++; if (o_count !== 3'd0 || o_issue_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%0d/%b exp=0/0", o_count, o_issue_valid); end
  endtask

  task automatic test_wakeup();
    tick();
    disp(4'b0001, 4'd2, 7'd1, 1'b1, 32'd3, 7'd12, 1'b0, 32'd0);
    tick();
    idle();
    #1;
    checks++; if (o_issue_valid !== 1'b0 || o_count !== 3'd1) begin failures++; $display("FAIL wake_wait got=%b/%0d exp=0/1", o_issue_valid, o_count); end
    tick();
    cdb(7'd12, 32'h7);
    #1;
`ifdef BRANCH_RS_BYPASS_EN
    checks++; if (o_issue_valid !== 1'b1 || o_issue_op2 !== 32'h7 || o_issue_op1 !== 32'd3) begin failures++; $display("FAIL wake_bypass got=%b/%h/%h exp=1/3/7", o_issue_valid, o_issue_op1, o_issue_op2); end
`else
    checks++; if (o_issue_valid !== 1'b0) begin failures++; $display("FAIL wake_early got=%b exp=0", o_issue_valid); end
`endif
    tick();
    idle();
    #1;
`ifdef BRANCH_RS_BYPASS_EN
    checks++; if (o_issue_valid !== 1'b0 || o_count !== 3'd0) begin failures++; $display("FAIL wake_after_bypass got=%b/%0d exp=0/0", o_issue_valid, o_count); end
`else
    checks++; if (o_issue_valid !== 1'b1 || o_issue_op2 !== 32'h7 || o_issue_op1 !== 32'd3 || o_issue_rob_tag !== 4'd2) begin failures++; $display("FAIL wake_issue got=%b/%h/%h/%h exp=1/3/7/2", o_issue_valid, o_issue_op1, o_issue_op2, o_issue_rob_tag); end
`endif
    tick();
    #1;
    checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL wake_drain got=%0d exp=0", o_count); end
  endtask

  task automatic test_full();
    h_rob.delete(); h_op1.delete(); h_op2.delete(); h_cyc.delete();
    for (int k = 0; k < 4; k++) begin
      tick();
      disp(4'b0100, 4'(4 + k), 7'(20 + k), 1'b0, 32'd0, 7'd0, 1'b1, 32'(k));
    end
    tick();
    idle();
    #1;
    checks++; if (o_count !== 3'd4 || o_disp_ready !== 1'b0) begin failures++; $display("FAIL full_state got=%0d/%b exp=4/0", o_count, o_disp_ready); end
    disp(4'b0000, 4'd15, 7'd0, 1'b1, 32'd1, 7'd0, 1'b1, 32'd1);
    tick();
    idle();
    #1;
    checks++; if (o_count !== 3'd4 || o_issue_valid !== 1'b0) begin failures++; $display("FAIL full_reject got=%0d/%b exp=4/0", o_count, o_issue_valid); end
    cdb(7'd22, 32'h55);
    tick();
    idle();
    tick();
    #1;
    checks++; if (o_count !== 3'd3 || h_rob.size() != 1) begin failures++; $display("FAIL full_wake2 got=%0d/%0d exp=3/1", o_count, h_rob.size()); end
    else begin
      checks++; if (h_rob[0] !== 4'd6 || h_op1[0] !== 32'h55 || h_op2[0] !== 32'd2) begin failures++; $display("FAIL full_wake2_fields got=%h/%h/%h exp=6/55/2", h_rob[0], h_op1[0], h_op2[0]); end
    end
    cdb(7'd23, 32'h77);
    tick();
    idle();
    tick();
    #1;
    checks++; if (o_count !== 3'd2 || h_rob.size() != 2) begin failures++; $display("FAIL full_order got=%0d/%0d exp=2/2", o_count, h_rob.size()); end
    else begin
      checks++; if (h_rob[1] !== 4'd7 || h_op1[1] !== 32'h77 || h_op2[1] !== 32'd3) begin failures++; $display("FAIL full_order_fields got=%h/%h/%h exp=7/77/3", h_rob[1], h_op1[1], h_op2[1]); end
    end
  endtask

  task automatic test_same_broadcast();
    tick();
    i_flush = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL same_preflush got=%0d exp=0", o_count); end
    h_rob.delete(); h_op1.delete(); h_op2.delete(); h_cyc.delete();
    disp(4'b0101, 4'd8, 7'd30, 1'b0, 32'd0, 7'd0, 1'b1, 32'd1);
    tick();
    disp(4'b0110, 4'd9, 7'd40, 1'b1, 32'd2, 7'd30, 1'b0, 32'd0);
    tick();
    idle();
    cdb(7'd30, 32'h99);
    tick();
    idle();
    repeat (2) tick();
    #1;
    checks++; if (h_rob.size() != 2 || o_count !== 3'd0) begin failures++; $display("FAIL same_count got=%0d/%0d exp=2/0", h_rob.size(), o_count); end
    else begin
      checks++; if (h_rob[0] !== 4'd8 || h_rob[1] !== 4'd9) begin failures++; $display("FAIL same_order got=%h,%h exp=8,9", h_rob[0], h_rob[1]); end
      checks++; if (h_op1[0] !== 32'h99 || h_op1[1] !== 32'd2 || h_op2[1] !== 32'h99) begin failures++; $display("FAIL same_ops got=%h/%h/%h exp=99/2/99", h_op1[0], h_op1[1], h_op2[1]); end
      checks++; if (h_cyc[1] - h_cyc[0] != 1) begin failures++; $display("FAIL same_gap got=%0d exp=1", h_cyc[1] - h_cyc[0]); end
    end
  endtask

  task automatic test_flush();
    h_rob.delete(); h_op1.delete(); h_op2.delete(); h_cyc.delete();
    for (int k = 0; k < 3; k++) begin
      tick();
      disp(4'b0111, 4'(1 + k), 7'(50 + k), 1'b0, 32'd0, 7'd0, 1'b1, 32'd0);
    end
    tick();
    disp(4'b0000, 4'd10, 7'd0, 1'b1, 32'd1, 7'd0, 1'b1, 32'd1);
    i_flush = 1'b1;
    #1;
    checks++; if (o_count !== 3'd3) begin failures++; $display("FAIL flush_pre got=%0d exp=3", o_count); end
    tick();
    idle();
    #1;
    checks++; if (o_count !== 3'd0 || o_issue_valid !== 1'b0) begin failures++; $display("FAIL flush_clear got=%0d/%b exp=0/0", o_count, o_issue_valid); end
    cdb(7'd50, 32'd1);
    tick();
    idle();
    repeat (2) tick();
    #1;
    checks++; if (h_rob.size() != 0 || o_count !== 3'd0) begin failures++; $display("FAIL flush_ghost got=%0d/%0d exp=0/0", h_rob.size(), o_count); end
  endtask

  task automatic test_dispatch_capture();
    tick();
    disp(4'b1001, 4'd11, 7'd9, 1'b0, 32'd0, 7'd0, 1'b1, 32'd4);
    cdb(7'd9, 32'h1234);
    tick();
    idle();
    #1;
    checks++; if (o_issue_valid !== 1'b1 || o_issue_op1 !== 32'h1234 || o_issue_op2 !== 32'd4 || o_issue_rob_tag !== 4'd11) begin failures++; $display("FAIL capture got=%b/%h/%h/%h exp=1/1234/4/b", o_issue_valid, o_issue_op1, o_issue_op2, o_issue_rob_tag); end
    checks++; if (o_issue_alu_op !== 4'b1001) begin failures++; $display("FAIL capture_op got=%h exp=9", o_issue_alu_op); end
    tick();
    #1;
    checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL capture_drain got=%0d exp=0", o_count); end
  endtask

  task automatic test_back_to_back();
    tick();
    disp(4'b1000, 4'd13, 7'd0, 1'b1, 32'd1, 7'd0, 1'b1, 32'd1);
    tick();
    disp(4'b1000, 4'd14, 7'd0, 1'b1, 32'd2, 7'd0, 1'b1, 32'd2);
    #1;
    checks++; if (o_issue_valid !== 1'b1 || o_issue_rob_tag !== 4'd13 || o_count !== 3'd1) begin failures++; $display("FAIL b2b_first got=%b/%h/%0d exp=1/d/1", o_issue_valid, o_issue_rob_tag, o_count); end
    tick();
    idle();
    #1;
    checks++; if (o_count !== 3'd1 || o_issue_rob_tag !== 4'd14 || o_issue_op1 !== 32'd2) begin failures++; $display("FAIL b2b_second got=%0d/%h/%h exp=1/e/2", o_count, o_issue_rob_tag, o_issue_op1); end
    tick();
    #1;
    checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", o_count); end
  endtask

  task automatic test_async_reset();
    tick();
    disp(4'b0000, 4'd12, 7'd0, 1'b1, 32'hAB, 7'd0, 1'b1, 32'hCD);
    tick();
    idle();
    #1;
    checks++; if (o_issue_valid !== 1'b1 || o_issue_op1 !== 32'hAB) begin failures++; $display("FAIL arst_pre got=%b/%h exp=1/ab", o_issue_valid, o_issue_op1); end
    #1 i_rst_n = 1'b0;
    #1;
    checks++; if (o_issue_valid !== 1'b0 || o_issue_op1 !== 32'd0 || o_issue_op2 !== 32'd0 || o_issue_rob_tag !== 4'd0) begin failures++; $display("FAIL arst_outputs got=%b/%h/%h/%h exp=0/0/0/0", o_issue_valid, o_issue_op1, o_issue_op2, o_issue_rob_tag); end
    checks++; if (o_count !== 3'd0 || o_disp_ready !== 1'b1) begin failures++; $display("FAIL arst_count got=%0d/%b exp=0/1", o_count, o_disp_ready); end
    tick();
    i_rst_n = 1'b1;
    tick();
    #1;
    checks++; if (o_issue_valid !== 1'b0 || o_count !== 3'd0) begin failures++; $display("FAIL arst_after got=%b/%0d exp=0/0", o_issue_valid, o_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_full();
    test_same_broadcast();
    test_flush();
    test_dispatch_capture();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
